// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-write controller and its users:
// frame geometry, peripheral register map, controller state encoding and a
// frame packing helper.
// Frame layout: bit 15 = write flag, bits 14:8 = address, bits 7:0 = data.
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   // Register map of the on-chip SPI register peripheral.
   localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
   localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
   localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;
   localparam logic [ADDR_W-1:0] MAX_ADDRESS     = 7'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_HI,
      ST_SHIFT_LO,
      ST_HOLD,
      ST_GAP
   } state_t;

   function automatic logic [FRAME_W-1:0] pack_frame(input logic              wr,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      return {wr, addr, data};
   endfunction

endpackage

// File: rtl/spi_controller_if.sv
// -----------------------------------------------------------------------------
// spi_controller_if
// Request handshake plus SPI pins of the SPI write controller.
//   start/wr/addr/wdata : frame request from the user logic
//   busy/done           : frame status back to the user logic
//   nCS/SCLK/COPI       : SPI pins towards the register peripheral
//   CIPO/rdata          : read-back path, only with SPI_CONTROLLER_CIPO_EN
// Modports: master = the controller (SPI bus master), slave = the side that
// issues requests and hosts the peripheral pins.
// -----------------------------------------------------------------------------
interface spi_controller_if;
   import spi_pkg::*;

   logic              start;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              nCS;
   logic              SCLK;
   logic              COPI;
`ifdef SPI_CONTROLLER_CIPO_EN
   logic               CIPO;
   logic [FRAME_W-1:0] rdata;
`endif

   modport master (
      input  start, wr, addr, wdata,
`ifdef SPI_CONTROLLER_CIPO_EN
      input  CIPO,
      output rdata,
`endif
      output busy, done, nCS, SCLK, COPI
   );

   modport slave (
      output start, wr, addr, wdata,
`ifdef SPI_CONTROLLER_CIPO_EN
      output CIPO,
      input  rdata,
`endif
      input  busy, done, nCS, SCLK, COPI
   );

endinterface

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Down-counter that times one controller phase. Loading N-1 makes expire_o
// assert in the N-th cycle after the load; the counter then parks at zero
// (no wrap) and goes inactive unless it is reloaded in that same cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : start a new interval
//   load_val_i   : interval length minus one
//   expire_o     : last cycle of the current interval
// -----------------------------------------------------------------------------
module spi_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic         active_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same edge, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (load_i) begin
         cnt_q    <= load_val_i;
         active_q <= 1'b1;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end else begin
         active_q <= 1'b0;
      end
   end

   assign expire_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// SPI mode-0, MSB-first write controller. Serialises 16-bit register-write
// frames {wr, addr[6:0], wdata[7:0]} onto nCS/SCLK/COPI, then keeps nCS high
// for GAP_CYCLES before signalling done. All pin and status outputs are
// registered.
// Parameters:
//   CLK_DIV    : SCLK half-period in clk cycles (2..255)
//   GAP_CYCLES : nCS-high cycles after a frame before done (4..255)
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : spi_controller_if.master (request, status and SPI pins)
// Optional feature macro SPI_CONTROLLER_CIPO_EN: samples CIPO on every SCLK
// rising edge and presents the 16 captured bits on rdata in the done cycle.
// -----------------------------------------------------------------------------
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_controller_if.master  bus
);

   localparam int MAX_PHASE = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CNT_W     = $clog2(MAX_PHASE + 1);

   state_t             state_q;
   logic [FRAME_W-1:0] shreg_q;
   logic [4:0]         bits_q;
   logic               ncs_q;
   logic               sclk_q;
   logic               copi_q;
   logic               busy_q;
   logic               done_q;
`ifdef SPI_CONTROLLER_CIPO_EN
   logic [FRAME_W-1:0] rx_q;
   logic [FRAME_W-1:0] rdata_q;
`endif

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_expire;

   // Every phase except GAP reloads the timer on its own expiry, so the next
   // phase length is known from the current state alone.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = CNT_W'(CLK_DIV - 1);
      if (state_q == ST_IDLE) begin
         tmr_load = bus.start;
      end else if (state_q != ST_GAP) begin
         tmr_load = tmr_expire;
      end
      if (state_q == ST_HOLD) begin
         tmr_val = CNT_W'(GAP_CYCLES - 1);
      end
   end

   spi_phase_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bits_q  <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_CONTROLLER_CIPO_EN
         rx_q    <= '0;
         rdata_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               // Request fields are captured once here; later changes are ignored.
               if (bus.start) begin
                  shreg_q <= pack_frame(bus.wr, bus.addr, bus.wdata);
                  bits_q  <= 5'(FRAME_W);
                  ncs_q   <= 1'b0;
                  copi_q  <= bus.wr;
                  busy_q  <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_expire) begin
                  sclk_q  <= 1'b1;
`ifdef SPI_CONTROLLER_CIPO_EN
                  rx_q    <= {rx_q[FRAME_W-2:0], bus.CIPO};
`endif
                  state_q <= ST_SHIFT_HI;
               end
            end
            ST_SHIFT_HI: begin
               if (tmr_expire) begin
                  sclk_q <= 1'b0;
                  bits_q <= bits_q - 5'd1;
                  if (bits_q == 5'd1) begin
                     // Last bit stays on COPI through HOLD.
                     state_q <= ST_HOLD;
                  end else begin
                     shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                     copi_q  <= shreg_q[FRAME_W-2];
                     state_q <= ST_SHIFT_LO;
                  end
               end
            end
            ST_SHIFT_LO: begin
               if (tmr_expire) begin
                  sclk_q  <= 1'b1;
`ifdef SPI_CONTROLLER_CIPO_EN
                  rx_q    <= {rx_q[FRAME_W-2:0], bus.CIPO};
`endif
                  state_q <= ST_SHIFT_HI;
               end
            end
            ST_HOLD: begin
               if (tmr_expire) begin
                  ncs_q   <= 1'b1;
                  copi_q  <= 1'b0;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tmr_expire) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef SPI_CONTROLLER_CIPO_EN
                  rdata_q <= rx_q;
`endif
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.nCS  = ncs_q;
   assign bus.SCLK = sclk_q;
   assign bus.COPI = copi_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
`ifdef SPI_CONTROLLER_CIPO_EN
   assign bus.rdata = rdata_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Self-checking bench for spi_controller. A pin monitor timestamps nCS/SCLK/
// COPI/busy/done events; a behavioural loop-back peripheral collects bits on
// SCLK rising edges and commits a write only after exactly 16 edges with the
// write flag set and a mapped address. Expected timing comes from the frame
// timing formulas, expected register contents from a reference register array.
// -----------------------------------------------------------------------------
module tb_spi_controller;
   import spi_pkg::*;

   localparam int CD        = 4;
   localparam int GAP       = 8;
   localparam int FRAME_CYC = 33 * CD + GAP;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_controller_if bus ();

   spi_controller #(
      .CLK_DIV    (CD),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor and loop-back peripheral ----------------
   int   cyc = 0;
   always @(posedge clk) cyc++;

   int   ncs_falls[$], ncs_rises[$], rises[$], dones[$], busy_rises[$], busy_falls[$];
   logic rise_bits[$];
   logic [15:0] done_rdata[$];
   int   stab_err      = 0;
   int   pend_rise     = 0;
   bit   pend_valid    = 1'b0;
   int   last_copi_chg = -1000;
   logic p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_busy = 1'b0;

   logic [7:0]  per_regs [0:4];
   logic [7:0]  ref_regs [0:4];
   logic [15:0] per_sh  = '0;
   int          per_cnt = 0;

   always @(negedge clk) begin
      if (!bus.nCS && p_ncs) begin
         ncs_falls.push_back(cyc);
         per_cnt = 0;
         per_sh  = '0;
      end
      if (bus.nCS && !p_ncs) begin
         ncs_rises.push_back(cyc);
         if (per_cnt == 16 && per_sh[15] && per_sh[14:8] <= MAX_ADDRESS)
            per_regs[per_sh[10:8]] = per_sh[7:0];
      end
      if (bus.SCLK && !p_sclk) begin
         rises.push_back(cyc);
         rise_bits.push_back(bus.COPI);
         if (!bus.nCS) begin
            per_sh = {per_sh[14:0], bus.COPI};
            per_cnt++;
         end
         if (cyc - last_copi_chg < CD) stab_err++;
         pend_rise  = cyc;
         pend_valid = 1'b1;
      end
      if (bus.COPI !== p_copi) begin
         if (pend_valid && (cyc - pend_rise < CD)) stab_err++;
         last_copi_chg = cyc;
      end
      if (bus.busy && !p_busy) busy_rises.push_back(cyc);
      if (!bus.busy && p_busy) busy_falls.push_back(cyc);
      if (bus.done) begin
         dones.push_back(cyc);
`ifdef SPI_CONTROLLER_CIPO_EN
         done_rdata.push_back(bus.rdata);
`endif
      end
      p_ncs  = bus.nCS;
      p_sclk = bus.SCLK;
      p_copi = bus.COPI;
      p_busy = bus.busy;
   end

`ifdef SPI_CONTROLLER_CIPO_EN
   // Peripheral read-back: presents 16'hC3A5 MSB first, next bit after each SCLK fall.
   logic [15:0] cipo_pat = 16'hC3A5;
   int   cipo_idx = -1;
   logic c_ncs = 1'b1, c_sclk = 1'b0;
   always @(negedge clk) begin
      if (bus.nCS) begin
         bus.CIPO = 1'b0;
      end else if (c_ncs) begin
         bus.CIPO = cipo_pat[15];
         cipo_idx = 14;
      end else if (!bus.SCLK && c_sclk && cipo_idx >= 0) begin
         bus.CIPO = cipo_pat[cipo_idx];
         cipo_idx--;
      end
      c_ncs  = bus.nCS;
      c_sclk = bus.SCLK;
   end
`endif

   // ---------------- driver helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      ncs_falls.delete(); ncs_rises.delete(); rises.delete(); dones.delete();
      busy_rises.delete(); busy_falls.delete(); rise_bits.delete(); done_rdata.delete();
      stab_err   = 0;
      pend_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n, input int budget, input string tag);
      int k = 0;
      while (dones.size() < n && k < budget) begin
         step();
         k++;
      end
      check({tag, " done_seen"}, 64'(dones.size() >= n), 64'd1);
   endtask

   function automatic logic [15:0] bits_at(input int off);
      logic [15:0] v = '0;
      for (int k = 0; k < 16; k++) v = {v[14:0], rise_bits[off + k]};
      return v;
   endfunction

   function automatic logic [39:0] pack_regs(input bit use_ref);
      logic [39:0] v = '0;
      for (int k = 0; k < 5; k++) v = {v[31:0], use_ref ? ref_regs[k] : per_regs[k]};
      return v;
   endfunction

   task automatic model_write(input logic w, input logic [6:0] a, input logic [7:0] d);
      if (w && a <= MAX_ADDRESS) ref_regs[a[2:0]] = d;
   endtask

   // One complete frame with full timing/content checks.
   task automatic run_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                            input bit noisy, input logic [15:0] exp_frame, input string tag);
      int t;
      int bad = 0;
      step();
      clear_mon();
      bus.start = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
      t = cyc;
      model_write(w, a, d);
      step();
      bus.start = 1'b0;
      if (noisy) begin
         for (int i = 0; i < 100; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.wr    = 1'($urandom);
            bus.addr  = 7'($urandom);
            bus.wdata = 8'($urandom);
            step();
         end
         bus.start = 1'b0;
      end
      wait_dones(1, FRAME_CYC + 20, tag);
      for (int i = 0; i < 4; i++) step();
      check({tag, " ncs_fall"},  64'(ncs_falls[0]),  64'(t + 1));
      check({tag, " busy_rise"}, 64'(busy_rises[0]), 64'(t + 1));
      check({tag, " sclk_rises"}, 64'(rises.size()), 64'd16);
      for (int k = 0; k < 16; k++)
         if (rises[k] != t + 1 + CD + 2 * CD * k) bad++;
      check({tag, " rise_timing_errs"}, 64'(bad), 64'd0);
      check({tag, " frame_bits"}, 64'(bits_at(0)), 64'(exp_frame));
      check({tag, " ncs_rise"}, 64'(ncs_rises[0]), 64'(t + 1 + 33 * CD));
      check({tag, " done_cycle"}, 64'(dones[0]), 64'(t + 1 + 33 * CD + GAP));
      check({tag, " busy_fall"}, 64'(busy_falls[0]), 64'(t + 1 + 33 * CD + GAP));
      check({tag, " copi_stability_errs"}, 64'(stab_err), 64'd0);
      check({tag, " frame_count"}, 64'(ncs_falls.size() * 16 + dones.size()), 64'd17);
      check({tag, " periph_regs"}, 64'(pack_regs(1'b0)), 64'(pack_regs(1'b1)));
`ifdef SPI_CONTROLLER_CIPO_EN
      check({tag, " rdata"}, 64'(done_rdata[0]), 64'h0000_0000_0000_C3A5);
`endif
   endtask

   typedef struct {
      logic        wr;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      bit          noisy;
      logic [15:0] exp_frame;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int t;
      vecs[0] = '{1'b1, 7'd0, 8'hA5, 1'b0, 16'h80A5};
      vecs[1] = '{1'b0, 7'd1, 8'h3C, 1'b0, 16'h013C};
      vecs[2] = '{1'b1, 7'd3, 8'h5A, 1'b0, 16'h835A};
      vecs[3] = '{1'b1, 7'd1, 8'hC7, 1'b1, 16'h81C7};
      vecs[4] = '{1'b1, 7'd9, 8'h11, 1'b0, 16'h8911};
      vecs[5] = '{1'b1, 7'd4, 8'h00, 1'b1, 16'h8400};

      for (int k = 0; k < 5; k++) begin
         per_regs[k] = 8'h00;
         ref_regs[k] = 8'h00;
      end
      bus.start = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;

      // Reset state
      step(); step();
      check("reset nCS",  64'(bus.nCS),  64'd1);
      check("reset SCLK", 64'(bus.SCLK), 64'd0);
      check("reset COPI", 64'(bus.COPI), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
`ifdef SPI_CONTROLLER_CIPO_EN
      check("reset rdata", 64'(bus.rdata), 64'd0);
`endif
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // Directed table
      for (int v = 0; v < 6; v++)
         run_frame(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].noisy,
                   vecs[v].exp_frame, $sformatf("vec%0d", v));
      check("wr0 leaves en_reg_out_15_8 only via later write", 64'(per_regs[1]), 64'h0000_0000_0000_00C7);

      // Back-to-back: start held high, second request accepted in the done cycle
      step();
      clear_mon();
      bus.start = 1'b1; bus.wr = 1'b1; bus.addr = 7'd4; bus.wdata = 8'h80;
      t = cyc;
      model_write(1'b1, 7'd4, 8'h80);
      wait_dones(1, FRAME_CYC + 20, "b2b first");
      bus.addr = 7'd2; bus.wdata = 8'hFF;
      model_write(1'b1, 7'd2, 8'hFF);
      step();
      bus.start = 1'b0;
      wait_dones(2, FRAME_CYC + 20, "b2b second");
      for (int i = 0; i < 4; i++) step();
      check("b2b first ncs_fall", 64'(ncs_falls[0]), 64'(t + 1));
      check("b2b second ncs_fall", 64'(ncs_falls[1]), 64'(t + 2 + 33 * CD + GAP));
      check("b2b second done", 64'(dones[1]), 64'(t + 2 * (1 + 33 * CD + GAP)));
      check("b2b frames", 64'({bits_at(0), bits_at(16)}), 64'h0000_0000_8480_82FF);
      check("b2b pwm_duty", 64'(per_regs[4]), 64'h80);
      check("b2b en_pwm_7_0", 64'(per_regs[2]), 64'hFF);
      check("b2b done_count", 64'(dones.size()), 64'd2);

      // Reset after the 5th SCLK rise aborts the frame with no peripheral write
      step();
      clear_mon();
      bus.start = 1'b1; bus.wr = 1'b1; bus.addr = 7'd3; bus.wdata = 8'h77;
      step();
      bus.start = 1'b0;
      begin
         int k = 0;
         while (rises.size() < 5 && k < FRAME_CYC) begin
            step();
            k++;
         end
      end
      check("abort reached 5th rise", 64'(rises.size()), 64'd5);
      rst_n = 1'b0;
      #1;
      check("abort nCS",  64'(bus.nCS),  64'd1);
      check("abort SCLK", 64'(bus.SCLK), 64'd0);
      check("abort COPI", 64'(bus.COPI), 64'd0);
      check("abort busy", 64'(bus.busy), 64'd0);
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("abort periph_regs", 64'(pack_regs(1'b0)), 64'(pack_regs(1'b1)));
      run_frame(1'b1, 7'd3, 8'h77, 1'b0, 16'h8377, "post_reset");

      // Randomised frames against the reference register model
      for (int r = 0; r < 20; r++) begin
         logic       w;
         logic [6:0] a;
         logic [7:0] d;
         w = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 4));
         d = 8'($urandom);
         run_frame(w, a, d, ($urandom_range(0, 4) == 0), {w, a, d}, $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
